endec_job_arbiter: RTL and testbench
====================================

Name: endec_job_arbiter

Overview:
- Schedules the shared endec core between two requesters: an encode-job port (128-bit frames) and a decode-job port (384-bit frames).
- Grants one job at a time, round-robin when both are pending.
- Per job: latches config, clears the core, runs it until done or timeout, then returns a result over a valid/ready response port.
- Sits directly above endec in the top level.

Parameters:
- ENC_W, 128, encode input frame / decoder output width
- DEC_W, 384, decode input frame / encoder output width
- GP_W, 27, flattened generator-polynomial width (MAX_CONSTRAINT_LENGTH*MAX_CODE_RATE)
- CLR_CYC, 2, core-reset cycles before each job (>=1)
- TIMEOUT_CYC, 1024, max RUN cycles before abort (>=2)

Ports:
- sys_clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- cfg_code_rate  in  1  code rate, sampled at grant
- cfg_gen_poly  in  GP_W  generator polynomials, sampled at grant
- enc_req_valid  in  1  encode job pending
- enc_req_ready  out  1  encode job accepted this cycle
- enc_req_frame  in  ENC_W  data to encode
- dec_req_valid  in  1  decode job pending
- dec_req_ready  out  1  decode job accepted this cycle
- dec_req_frame  in  DEC_W  data to decode
- resp_valid  out  1  result available
- resp_ready  in  1  result consumed
- resp_is_dec  out  1  1 = decode result, 0 = encode result
- resp_timeout  out  1  job aborted by timeout
- resp_data  out  DEC_W  encoder output, or decoder output zero-extended
- core_rst  out  1  active-low reset to endec
- core_en  out  1  endec en
- core_code_rate  out  1  latched code rate
- core_gen_poly  out  GP_W  latched polynomials
- core_enc_frame  out  ENC_W  latched encode frame (0 for decode jobs)
- core_dec_frame  out  DEC_W  latched decode frame (0 for encode jobs)
- core_enc_data  in  DEC_W  endec o_encoder_data
- core_enc_done  in  1  endec o_encoder_done
- core_dec_data  in  ENC_W  endec o_decoder_data
- core_dec_done  in  1  endec o_decoder_done
- busy  out  1  state != IDLE

Behaviour:
- Reset values:
  - Outputs: all readies, resp_valid, resp_* and resp_data = 0; core_rst = 0 (core held in reset); core_en = 0; core config/frames = 0; busy = 0.
  - State: IDLE; last_grant = dec, so encode wins the first tie.
- IDLE:
  - Grant rule: if exactly one valid is high, grant it; if both are high, grant the one not equal to last_grant.
  - Granted *_req_ready is high combinationally in that same cycle (single-cycle accept); the other ready stays low.
  - On accept: latch frame, cfg_code_rate, cfg_gen_poly and job type; update last_grant; go to CLR.
  - core_rst stays asserted (0) throughout IDLE.
- CLR:
  - core_rst = 0 and core_en = 0 for exactly CLR_CYC cycles; then go to RUN.
- RUN:
  - core_rst = 1, core_en = 1.
  - Timeout counter starts at 0 on entry and increments each cycle.
  - Done: the matching done (enc_done for encode jobs, dec_done for decode jobs), seen high on any RUN cycle after the first, completes the job.
    - Capture the matching data into resp_data; resp_timeout = 0.
    - Deassert core_en next cycle; go to RESP.
  - The non-matching done is ignored.
  - Timeout: counter reaching TIMEOUT_CYC-1 without done → resp_data = 0, resp_timeout = 1, go to RESP.
  - Done and timeout in the same cycle → done wins.
- RESP:
  - resp_valid = 1, core_en = 0, core_rst = 0.
  - resp_* held stable until resp_ready; on resp_valid && resp_ready go to IDLE, with resp_valid low the next cycle.
  - No new request is accepted while in RESP (readies low), so at most one outstanding job.
- Latency, accept to resp_valid: 1 + CLR_CYC + N cycles, where N = core run cycles to done.
- Request valids may drop without acceptance; no penalty, and last_grant is unchanged.
- Reset asserted mid-job: immediate return to reset values; any in-flight job is discarded, with no response.
- Counters are width-sized as $clog2(TIMEOUT_CYC+1) and $clog2(CLR_CYC+1); no wrap is possible.

Optional Feature:
- Macro: ENDEC_ARB_STATS_EN.
- When defined: adds outputs stat_enc_jobs[15:0], stat_dec_jobs[15:0] and stat_timeouts[15:0].
  - Each increments on entry to RESP for its category; a timeout counts in both its type counter and stat_timeouts.
  - Counters saturate at 16'hFFFF, reset to 0, and are cleared by a 1-cycle stat_clr input (clear wins over a simultaneous increment).
- When undefined: these ports and the logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (param_def.sv):
  - State enum arb_state_t {IDLE, CLR, RUN, RESP}.
  - job_type_t {JOB_ENC, JOB_DEC}.
  - Defaults for ENC_W, DEC_W and GP_W derived from MAX_CONSTRAINT_LENGTH and MAX_CODE_RATE.
- One natural sub-module: endec_rr_grant, the two-requester round-robin grant with a last_grant register.
- The FSM, counters and datapath latches stay in the top.

Test Plan:
- Single encode: enc frame 128'h1, core_enc_done after 300 RUN cycles → resp_valid at cycle 1+2+300 after accept; resp_is_dec=0; resp_data = core_enc_data; resp_timeout=0.
- Simultaneous requests from reset: both valids high → encode granted first; after its response, decode granted; a third tie goes to encode; enc_req_ready and dec_req_ready never high together.
- Timeout: decode job, core_dec_done never asserted, TIMEOUT_CYC=16 → after 16 RUN cycles resp_timeout=1, resp_data=0, core_en=0.
- Backpressure: resp_ready held low 10 cycles → resp_* stable, both readies low; resp_ready=1 → IDLE next cycle.
- Reset mid-RUN: rst=0 during RUN → core_rst=0, core_en=0, resp_valid=0 immediately, state IDLE; no response after release.
- ENDEC_ARB_STATS_EN: 3 encode jobs, 2 decode jobs (1 timeout) → counters 3/2/1; stat_clr → all 0.

Source files
------------

// File: rtl/endec_job_arbiter_pkg.sv
// Shared types and width defaults for the endec job arbiter slice.
package endec_job_arbiter_pkg;

  localparam int MAX_CONSTRAINT_LENGTH = 9;
  localparam int MAX_CODE_RATE         = 3;

  localparam int ENC_W_DEF = 128;
  localparam int DEC_W_DEF = ENC_W_DEF * MAX_CODE_RATE;
  localparam int GP_W_DEF  = MAX_CONSTRAINT_LENGTH * MAX_CODE_RATE;

  typedef enum logic [1:0] {IDLE, CLR, RUN, RESP} arb_state_t;

  typedef enum logic {JOB_ENC, JOB_DEC} job_type_t;

endpackage

// File: rtl/endec_job_arbiter_if.sv
// Request/response bundle between the job requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface endec_job_arbiter_if
  import endec_job_arbiter_pkg::*;
#(
  parameter int ENC_W = ENC_W_DEF,
  parameter int DEC_W = DEC_W_DEF,
  parameter int GP_W  = GP_W_DEF
);

  logic             cfg_code_rate;
  logic [GP_W-1:0]  cfg_gen_poly;

  logic             enc_req_valid;
  logic             enc_req_ready;
  logic [ENC_W-1:0] enc_req_frame;

  logic             dec_req_valid;
  logic             dec_req_ready;
  logic [DEC_W-1:0] dec_req_frame;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_is_dec;
  logic             resp_timeout;
  logic [DEC_W-1:0] resp_data;

  modport master (
    output cfg_code_rate, cfg_gen_poly,
    output enc_req_valid, enc_req_frame,
    output dec_req_valid, dec_req_frame,
    output resp_ready,
    input  enc_req_ready, dec_req_ready,
    input  resp_valid, resp_is_dec, resp_timeout, resp_data
  );

  modport slave (
    input  cfg_code_rate, cfg_gen_poly,
    input  enc_req_valid, enc_req_frame,
    input  dec_req_valid, dec_req_frame,
    input  resp_ready,
    output enc_req_ready, dec_req_ready,
    output resp_valid, resp_is_dec, resp_timeout, resp_data
  );

endinterface

// File: rtl/endec_job_arbiter_rr_grant.sv
// Two-requester round-robin grant. Grants are only issued while enabled
// (arbiter idle); a grant is an acceptance, so last_grant moves with it.
module endec_rr_grant
  import endec_job_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic enc_valid,
  input  logic dec_valid,
  output logic grant_enc,
  output logic grant_dec
);

  job_type_t last_grant;

  // Single requester wins outright; on a tie the side not served last wins.
  always_comb begin
    grant_enc = 1'b0;
    grant_dec = 1'b0;
    if (en) begin
      if (enc_valid && dec_valid) begin
        grant_enc = (last_grant == JOB_DEC);
        grant_dec = (last_grant == JOB_ENC);
      end else begin
        grant_enc = enc_valid;
        grant_dec = dec_valid;
      end
    end
  end

  // Remember who was served; reset favours encode on the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= JOB_DEC;
    end else if (grant_enc) begin
      last_grant <= JOB_ENC;
    end else if (grant_dec) begin
      last_grant <= JOB_DEC;
    end
  end

endmodule

// File: rtl/endec_job_arbiter.sv
// Schedules the shared endec core between encode and decode job requesters.
// One job at a time: accept, hold core in reset CLR_CYC cycles, run until
// done or TIMEOUT_CYC, then present the result until consumed.
// Optional job statistics counters are built when ENDEC_ARB_STATS_EN is defined.
module endec_job_arbiter
  import endec_job_arbiter_pkg::*;
#(
  parameter int ENC_W       = ENC_W_DEF,
  parameter int DEC_W       = DEC_W_DEF,
  parameter int GP_W        = GP_W_DEF,
  parameter int CLR_CYC     = 2,
  parameter int TIMEOUT_CYC = 1024
)(
  input  logic             sys_clk,
  input  logic             rst,
  endec_job_arbiter_if.slave req_bus,
  output logic             core_rst,
  output logic             core_en,
  output logic             core_code_rate,
  output logic [GP_W-1:0]  core_gen_poly,
  output logic [ENC_W-1:0] core_enc_frame,
  output logic [DEC_W-1:0] core_dec_frame,
  output logic             busy,
  input  logic [DEC_W-1:0] core_enc_data,
  input  logic             core_enc_done,
  input  logic [ENC_W-1:0] core_dec_data,
  input  logic             core_dec_done
`ifdef ENDEC_ARB_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [15:0]      stat_enc_jobs,
  output logic [15:0]      stat_dec_jobs,
  output logic [15:0]      stat_timeouts
`endif
);

  localparam int CLR_W = $clog2(CLR_CYC + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  arb_state_t       state;
  job_type_t        job_type;
  logic [CLR_W-1:0] clr_cnt;
  logic [TO_W-1:0]  run_cnt;

  logic             resp_valid_q;
  logic             resp_is_dec_q;
  logic             resp_timeout_q;
  logic [DEC_W-1:0] resp_data_q;

  logic grant_enc;
  logic grant_dec;
  logic match_done;
  logic run_done;
  logic run_timeout;

  endec_rr_grant u_grant (
    .clk       (sys_clk),
    .rst_n     (rst),
    .en        (state == IDLE),
    .enc_valid (req_bus.enc_req_valid),
    .dec_valid (req_bus.dec_req_valid),
    .grant_enc (grant_enc),
    .grant_dec (grant_dec)
  );

  assign req_bus.enc_req_ready = grant_enc;
  assign req_bus.dec_req_ready = grant_dec;
  assign req_bus.resp_valid    = resp_valid_q;
  assign req_bus.resp_is_dec   = resp_is_dec_q;
  assign req_bus.resp_timeout  = resp_timeout_q;
  assign req_bus.resp_data     = resp_data_q;
  assign busy                  = (state != IDLE);

  // The first RUN cycle follows core reset release, so its done is not trusted.
  assign match_done  = (job_type == JOB_DEC) ? core_dec_done : core_enc_done;
  assign run_done    = match_done && (run_cnt != '0);
  assign run_timeout = (run_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Job FSM with the config/frame latches, core controls and response registers.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      job_type       <= JOB_ENC;
      clr_cnt        <= '0;
      run_cnt        <= '0;
      core_rst       <= 1'b0;
      core_en        <= 1'b0;
      core_code_rate <= 1'b0;
      core_gen_poly  <= '0;
      core_enc_frame <= '0;
      core_dec_frame <= '0;
      resp_valid_q   <= 1'b0;
      resp_is_dec_q  <= 1'b0;
      resp_timeout_q <= 1'b0;
      resp_data_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_enc || grant_dec) begin
            job_type       <= grant_dec ? JOB_DEC : JOB_ENC;
            core_code_rate <= req_bus.cfg_code_rate;
            core_gen_poly  <= req_bus.cfg_gen_poly;
            core_enc_frame <= grant_enc ? req_bus.enc_req_frame : '0;
            core_dec_frame <= grant_dec ? req_bus.dec_req_frame : '0;
            clr_cnt        <= '0;
            state          <= CLR;
          end
        end
        CLR: begin
          if (clr_cnt == CLR_W'(CLR_CYC - 1)) begin
            run_cnt  <= '0;
            core_rst <= 1'b1;
            core_en  <= 1'b1;
            state    <= RUN;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        RUN: begin
          if (run_done || run_timeout) begin
            resp_valid_q   <= 1'b1;
            resp_is_dec_q  <= (job_type == JOB_DEC);
            resp_timeout_q <= !run_done;
            if (!run_done) begin
              resp_data_q <= '0;
            end else if (job_type == JOB_DEC) begin
              resp_data_q <= {{(DEC_W - ENC_W){1'b0}}, core_dec_data};
            end else begin
              resp_data_q <= core_enc_data;
            end
            core_en  <= 1'b0;
            core_rst <= 1'b0;
            state    <= RESP;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        RESP: begin
          if (req_bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ENDEC_ARB_STATS_EN
  logic enter_resp;
  assign enter_resp = (state == RUN) && (run_done || run_timeout);

  // Saturating per-category job counters, bumped as each job reaches RESP.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      stat_enc_jobs <= '0;
      stat_dec_jobs <= '0;
      stat_timeouts <= '0;
    end else if (stat_clr) begin
      stat_enc_jobs <= '0;
      stat_dec_jobs <= '0;
      stat_timeouts <= '0;
    end else if (enter_resp) begin
      if (job_type == JOB_ENC && stat_enc_jobs != 16'hFFFF) begin
        stat_enc_jobs <= stat_enc_jobs + 16'd1;
      end
      if (job_type == JOB_DEC && stat_dec_jobs != 16'hFFFF) begin
        stat_dec_jobs <= stat_dec_jobs + 16'd1;
      end
      if (!run_done && stat_timeouts != 16'hFFFF) begin
        stat_timeouts <= stat_timeouts + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_endec_job_arbiter.sv
// Directed + randomized bench for endec_job_arbiter. The bench plays the
// endec core itself and predicts each response from the job rules.
module tb_endec_job_arbiter;
  import endec_job_arbiter_pkg::*;

  localparam int ENC_W = ENC_W_DEF;
  localparam int DEC_W = DEC_W_DEF;
  localparam int GP_W  = GP_W_DEF;
  localparam int CLR   = 2;
  localparam int TO    = 400;

  logic             sys_clk = 1'b0;
  logic             rst;
  logic             core_rst;
  logic             core_en;
  logic             core_code_rate;
  logic [GP_W-1:0]  core_gen_poly;
  logic [ENC_W-1:0] core_enc_frame;
  logic [DEC_W-1:0] core_dec_frame;
  logic             busy;
  logic [DEC_W-1:0] core_enc_data;
  logic             core_enc_done;
  logic [ENC_W-1:0] core_dec_data;
  logic             core_dec_done;
`ifdef ENDEC_ARB_STATS_EN
  logic             stat_clr;
  logic [15:0]      stat_enc_jobs;
  logic [15:0]      stat_dec_jobs;
  logic [15:0]      stat_timeouts;
`endif

  int total = 0;
  int bad   = 0;

  bit last_grant_dec = 1'b1;
  int model_enc_jobs = 0;
  int model_dec_jobs = 0;
  int model_timeouts = 0;

  logic [ENC_W-1:0] enc_frame;
  logic [DEC_W-1:0] dec_frame;

  endec_job_arbiter_if #(.ENC_W(ENC_W), .DEC_W(DEC_W), .GP_W(GP_W)) req_bus ();

  endec_job_arbiter #(
    .ENC_W(ENC_W), .DEC_W(DEC_W), .GP_W(GP_W), .CLR_CYC(CLR), .TIMEOUT_CYC(TO)
  ) dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .req_bus        (req_bus),
    .core_rst       (core_rst),
    .core_en        (core_en),
    .core_code_rate (core_code_rate),
    .core_gen_poly  (core_gen_poly),
    .core_enc_frame (core_enc_frame),
    .core_dec_frame (core_dec_frame),
    .busy           (busy),
    .core_enc_data  (core_enc_data),
    .core_enc_done  (core_enc_done),
    .core_dec_data  (core_dec_data),
    .core_dec_done  (core_dec_done)
`ifdef ENDEC_ARB_STATS_EN
    ,
    .stat_clr       (stat_clr),
    .stat_enc_jobs  (stat_enc_jobs),
    .stat_dec_jobs  (stat_dec_jobs),
    .stat_timeouts  (stat_timeouts)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_output(input string tag, input logic [DEC_W-1:0] obs,
                              input logic [DEC_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DEC_W-1:0] rand_wide();
    logic [DEC_W-1:0] v;
    v = '0;
    for (int i = 0; i < DEC_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One complete job from an idle arbiter: request, emulate the core finishing
  // on RUN cycle n (n > TO means never), optional response backpressure.
  task automatic apply_stimulus(input bit req_enc, input bit req_dec, input int n,
                                input int hold, input bit noise);
    bit               grant_dec;
    bit               exp_to;
    bit               seen;
    int               eff;
    int               lat;
    int               cyc;
    int               run_idx;
    logic             exp_rate;
    logic [GP_W-1:0]  exp_poly;
    logic [DEC_W-1:0] exp_data;
    logic [DEC_W-1:0] tmp;

    grant_dec = req_dec && (!req_enc || !last_grant_dec);
    exp_rate  = 1'($urandom_range(0, 1));
    tmp       = rand_wide();
    exp_poly  = tmp[GP_W-1:0];
    core_enc_data = rand_wide();
    tmp           = rand_wide();
    core_dec_data = tmp[ENC_W-1:0];

    req_bus.cfg_code_rate = exp_rate;
    req_bus.cfg_gen_poly  = exp_poly;
    req_bus.enc_req_frame = enc_frame;
    req_bus.dec_req_frame = dec_frame;
    req_bus.enc_req_valid = req_enc;
    req_bus.dec_req_valid = req_dec;
    #1;
    check_output("enc_req_ready", DEC_W'(req_bus.enc_req_ready), DEC_W'(req_enc && !grant_dec));
    check_output("dec_req_ready", DEC_W'(req_bus.dec_req_ready), DEC_W'(grant_dec));

    last_grant_dec = grant_dec;
    eff      = (n < 2) ? 2 : n;
    exp_to   = (eff > TO);
    lat      = 1 + CLR + (exp_to ? TO : eff);
    exp_data = exp_to ? '0 :
               grant_dec ? {{(DEC_W - ENC_W){1'b0}}, core_dec_data} : core_enc_data;

    cyc = 0; run_idx = 0; seen = 1'b0;
    while (!seen && cyc < lat + 20) begin
      @(negedge sys_clk);
      cyc++;
      if (cyc == 1) begin
        req_bus.enc_req_valid = 1'b0;
        req_bus.dec_req_valid = 1'b0;
        check_output("clr_busy", DEC_W'(busy), DEC_W'(1));
        check_output("clr_core_ctl", DEC_W'({core_rst, core_en}), DEC_W'(0));
      end
      if (core_en === 1'b1 && core_rst === 1'b1) begin
        if (run_idx == 0) begin
          check_output("core_code_rate", DEC_W'(core_code_rate), DEC_W'(exp_rate));
          check_output("core_gen_poly", DEC_W'(core_gen_poly), DEC_W'(exp_poly));
          check_output("core_enc_frame", DEC_W'(core_enc_frame), grant_dec ? '0 : DEC_W'(enc_frame));
          check_output("core_dec_frame", core_dec_frame, grant_dec ? dec_frame : '0);
        end
        if (run_idx >= n - 1) begin
          core_enc_done = !grant_dec;
          core_dec_done = grant_dec;
        end
        if (noise) begin
          if (grant_dec) core_enc_done = 1'b1;
          else           core_dec_done = 1'b1;
        end
        run_idx++;
      end
      if (req_bus.resp_valid === 1'b1) seen = 1'b1;
    end
    core_enc_done = 1'b0;
    core_dec_done = 1'b0;

    check_output("latency", DEC_W'(cyc), DEC_W'(lat));
    check_output("resp_is_dec", DEC_W'(req_bus.resp_is_dec), DEC_W'(grant_dec));
    check_output("resp_timeout", DEC_W'(req_bus.resp_timeout), DEC_W'(exp_to));
    check_output("resp_data", req_bus.resp_data, exp_data);
    check_output("resp_core_ctl", DEC_W'({core_rst, core_en}), DEC_W'(0));

    for (int h = 0; h < hold; h++) begin
      req_bus.enc_req_valid = 1'b1;
      req_bus.dec_req_valid = 1'b1;
      #1;
      check_output("bp_readies", DEC_W'({req_bus.enc_req_ready, req_bus.dec_req_ready}), DEC_W'(0));
      check_output("bp_valid", DEC_W'(req_bus.resp_valid), DEC_W'(1));
      check_output("bp_data", req_bus.resp_data, exp_data);
      check_output("bp_flags", DEC_W'({req_bus.resp_is_dec, req_bus.resp_timeout}),
                   DEC_W'({grant_dec, exp_to}));
      @(negedge sys_clk);
    end
    req_bus.enc_req_valid = 1'b0;
    req_bus.dec_req_valid = 1'b0;
    req_bus.resp_ready    = 1'b1;
    @(negedge sys_clk);
    req_bus.resp_ready = 1'b0;
    check_output("resp_valid_drop", DEC_W'(req_bus.resp_valid), DEC_W'(0));
    check_output("idle_busy", DEC_W'(busy), DEC_W'(0));

    if (grant_dec) model_dec_jobs++;
    else           model_enc_jobs++;
    if (exp_to)    model_timeouts++;
  endtask

  initial begin
    bit rand_enc;
    bit rand_dec;
    int cnt;
    logic [DEC_W-1:0] tmp;

    rst = 1'b0;
    req_bus.cfg_code_rate = 1'b0;
    req_bus.cfg_gen_poly  = '0;
    req_bus.enc_req_valid = 1'b0;
    req_bus.enc_req_frame = '0;
    req_bus.dec_req_valid = 1'b0;
    req_bus.dec_req_frame = '0;
    req_bus.resp_ready    = 1'b0;
    core_enc_data = '0;
    core_enc_done = 1'b0;
    core_dec_data = '0;
    core_dec_done = 1'b0;
    enc_frame = '0;
    dec_frame = '0;
`ifdef ENDEC_ARB_STATS_EN
    stat_clr = 1'b0;
`endif

    repeat (3) @(negedge sys_clk);
    check_output("rst_resp_valid", DEC_W'(req_bus.resp_valid), DEC_W'(0));
    check_output("rst_resp_flags", DEC_W'({req_bus.resp_is_dec, req_bus.resp_timeout}), DEC_W'(0));
    check_output("rst_resp_data", req_bus.resp_data, '0);
    check_output("rst_core_ctl", DEC_W'({core_rst, core_en, core_code_rate}), DEC_W'(0));
    check_output("rst_core_poly", DEC_W'(core_gen_poly), '0);
    check_output("rst_core_frames", core_dec_frame | DEC_W'(core_enc_frame), '0);
    check_output("rst_busy", DEC_W'(busy), DEC_W'(0));
    rst = 1'b1;
    @(negedge sys_clk);
    check_output("idle_readies", DEC_W'({req_bus.enc_req_ready, req_bus.dec_req_ready}), DEC_W'(0));

    $display("[TB] tie-break sequence from reset");
    tmp = rand_wide(); enc_frame = tmp[ENC_W-1:0]; dec_frame = rand_wide();
    apply_stimulus(1'b1, 1'b1, 20, 0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 25, 1, 1'b0);
    apply_stimulus(1'b1, 1'b1, 5, 0, 1'b1);

    $display("[TB] single encode, 300 run cycles");
    enc_frame = 128'h1;
    apply_stimulus(1'b1, 1'b0, 300, 0, 1'b0);

    $display("[TB] decode timeout with 10-cycle backpressure");
    dec_frame = rand_wide();
    apply_stimulus(1'b0, 1'b1, TO + 50, 10, 1'b0);

    $display("[TB] done on the timeout cycle, done on first run cycle");
    apply_stimulus(1'b0, 1'b1, TO, 0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1, 0, 1'b0);

    $display("[TB] randomized jobs");
    for (int j = 0; j < 10; j++) begin
      tmp = rand_wide(); enc_frame = tmp[ENC_W-1:0]; dec_frame = rand_wide();
      rand_enc = 1'($urandom_range(0, 1));
      rand_dec = rand_enc ? 1'($urandom_range(0, 1)) : 1'b1;
      apply_stimulus(rand_enc, rand_dec, $urandom_range(2, 60), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)));
    end

`ifdef ENDEC_ARB_STATS_EN
    check_output("stat_enc_jobs", DEC_W'(stat_enc_jobs), DEC_W'(model_enc_jobs));
    check_output("stat_dec_jobs", DEC_W'(stat_dec_jobs), DEC_W'(model_dec_jobs));
    check_output("stat_timeouts", DEC_W'(stat_timeouts), DEC_W'(model_timeouts));
    stat_clr = 1'b1;
    @(negedge sys_clk);
    stat_clr = 1'b0;
    check_output("stat_cleared", DEC_W'({stat_enc_jobs, stat_dec_jobs, stat_timeouts}), '0);
`endif

    $display("[TB] reset during RUN");
    req_bus.dec_req_valid = 1'b1;
    #1;
    check_output("mid_dec_ready", DEC_W'(req_bus.dec_req_ready), DEC_W'(1));
    @(negedge sys_clk);
    req_bus.dec_req_valid = 1'b0;
    cnt = 0;
    while (core_en !== 1'b1 && cnt < 10) begin
      @(negedge sys_clk);
      cnt++;
    end
    check_output("mid_reached_run", DEC_W'(core_en), DEC_W'(1));
    repeat (5) @(negedge sys_clk);
    rst = 1'b0;
    #1;
    check_output("mid_rst_core_ctl", DEC_W'({core_rst, core_en}), DEC_W'(0));
    check_output("mid_rst_resp_valid", DEC_W'(req_bus.resp_valid), DEC_W'(0));
    check_output("mid_rst_busy", DEC_W'(busy), DEC_W'(0));
    @(negedge sys_clk);
    rst = 1'b1;
    req_bus.resp_ready = 1'b1;
    last_grant_dec = 1'b1;
    model_enc_jobs = 0;
    model_dec_jobs = 0;
    model_timeouts = 0;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge sys_clk);
      if (req_bus.resp_valid !== 1'b0) cnt++;
    end
    req_bus.resp_ready = 1'b0;
    check_output("mid_no_response", DEC_W'(cnt), DEC_W'(0));
    check_output("mid_idle_busy", DEC_W'(busy), DEC_W'(0));
`ifdef ENDEC_ARB_STATS_EN
    check_output("stat_after_rst", DEC_W'({stat_enc_jobs, stat_dec_jobs, stat_timeouts}), '0);
`endif

    $display("[TB] tie after reset goes to encode");
    apply_stimulus(1'b1, 1'b1, 10, 0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 12, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
